pp_interleave_buffer: RTL and testbench

Parametrised two-bank ping-pong buffer for the WiMAX bit-interleaver and de-interleaver path. It supersedes the fixed 1-bit/256-entry buffer with several additions: configurable word width and depth, a per-block runtime length, internal bank sequencing, and valid/ready handshakes on both sides with downstream backpressure. Upstream writes each block in permuted order through an explicit write address. Downstream drains each block in natural order from an internal read counter, with a last-word marker.

---
 rtl/pp_interleave_buffer_if.sv | 28 ++
 rtl/pp_interleave_buffer.sv | 117 +++++++++++
 tb/tb_pp_interleave_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_interleave_buffer_if.sv
// Write/read handshake bundle for pp_interleave_buffer: permuted-address write
// side and natural-order read side with backpressure.
`timescale 1ns/1ps
interface pp_interleave_buffer_if #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [ADDR_W:0]   blk_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output blk_len, in_valid, in_data, wr_addr, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  blk_len, in_valid, in_data, wr_addr, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pp_interleave_buffer.sv
// Two-bank ping-pong buffer for the WiMAX (de)interleaver: permuted writes, natural-order
// reads with last marker. Define PPBUF_ERR_EN to add the sticky err_flags port.
`timescale 1ns/1ps
module pp_interleave_buffer #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetN,
  pp_interleave_buffer_if.slave bus
`ifdef PPBUF_ERR_EN
  ,
  output logic [1:0]            err_flags
`endif
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  bank_state_e       state [2];
  logic [ADDR_W:0]   len   [2];
  logic              wb;
  logic              rb;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] rcnt;
  logic [DATA_W-1:0] mem [2][DEPTH];

  logic [ADDR_W:0] blk_len_eff;
  logic [ADDR_W:0] wr_len;
  logic [ADDR_W:0] rd_len;
  logic            wr_acc;
  logic            wr_last;
  logic            wr_in_range;
  logic            rd_issue;
  logic            rd_last;

  // An empty bank takes its length from the incoming word; otherwise the latched one.
  always_comb begin
    blk_len_eff = (bus.blk_len == '0 || bus.blk_len > DEPTH_L) ? DEPTH_L : bus.blk_len;
    wr_len      = (state[wb] == EMPTY) ? blk_len_eff : len[wb];
    rd_len      = len[rb];
  end

  assign bus.in_ready = (state[wb] != FULL);
  assign wr_acc       = bus.in_valid && bus.in_ready;
  assign wr_last      = ({1'b0, wcnt} == wr_len - ONE_L);
  assign wr_in_range  = ({1'b0, bus.wr_addr} < wr_len);
  assign rd_issue     = (state[rb] == FULL) && (!bus.out_valid || bus.out_ready);
  assign rd_last      = ({1'b0, rcnt} == rd_len - ONE_L);

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state[0]      <= EMPTY;
      state[1]      <= EMPTY;
      len[0]        <= '0;
      len[1]        <= '0;
      wb            <= 1'b0;
      rb            <= 1'b0;
      wcnt          <= '0;
      rcnt          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      // Write and read never target the same bank: one needs !FULL, the other FULL.
      if (wr_acc) begin
        if (state[wb] == EMPTY) len[wb] <= blk_len_eff;
        if (wr_last) begin
          state[wb] <= FULL;
          wb        <= ~wb;
          wcnt      <= '0;
        end else begin
          state[wb] <= FILLING;
          wcnt      <= wcnt + ONE_A;
        end
      end

      if (rd_issue) begin
        bus.out_data  <= mem[rb][rcnt];
        bus.out_valid <= 1'b1;
        bus.out_last  <= rd_last;
        if (rd_last) begin
          state[rb] <= EMPTY;
          rb        <= ~rb;
          rcnt      <= '0;
        end else begin
          rcnt <= rcnt + ONE_A;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

  // NOTE: the sample storage is deliberately not reset; partial blocks are discarded by the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && wr_in_range) mem[wb][bus.wr_addr] <= bus.in_data;
  end

`ifdef PPBUF_ERR_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_flags <= '0;
    end else begin
      if (bus.in_valid && !bus.in_ready) err_flags[0] <= 1'b1;
      if (wr_acc && !wr_in_range)        err_flags[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pp_interleave_buffer.sv
// Directed bench for pp_interleave_buffer (DATA_W=4, DEPTH=384): latency, ordering,
// backpressure, length clamping, mid-block reset and, with PPBUF_ERR_EN, error flags.
`timescale 1ns/1ps
module tb_pp_interleave_buffer;

  localparam int DW        = 4;
  localparam int DEPTH     = 384;
  localparam int AW        = 9;
  localparam int STALL_MAX = 2000;

  logic clk;
  logic resetN;
`ifdef PPBUF_ERR_EN
  logic [1:0] err_flags;
`endif

  pp_interleave_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  pp_interleave_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
`ifdef PPBUF_ERR_EN
    ,
    .err_flags (err_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int t_w = 0;
  int t_v = 0;
  bit seen_valid = 0;
  bit rand_ready = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(input int mode, input int i, input int len);
    case (mode)
      0:       return (13 * i) % len;
      1:       return len - 1 - i;
      2:       return (7 * i) % len;
      default: return i;
    endcase
  endfunction

  // One clock: score the word handed over at this edge, then step past the edge.
  task automatic tick(output bit w_acc);
    bit            held;
    logic [DW-1:0] held_d;
    logic [DW:0]   e;
    w_acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      check("word_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
        check("out_last", 32'(bus.out_last), 32'(e[DW]));
      end
    end
    held   = bus.out_valid && !bus.out_ready;
    held_d = bus.out_data;
    @(posedge clk);
    #1;
    edge_n++;
    if (held) begin
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_data", 32'(bus.out_data), 32'(held_d));
    end
    if (bus.out_valid && !seen_valid) begin
      seen_valid = 1;
      t_v = edge_n;
    end
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    bit w;
    for (int i = 0; i < n; i++) tick(w);
  endtask

  task automatic drain(input int budget);
    bit w;
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(w);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  // dmode: 0 = i[0], 1 = seed+3i, 2 = random. max_w > 0 stops the block early.
  task automatic write_block(input int len_in, input int amode, input int dmode,
                             input int seed, input bit push, input int max_w);
    int len;
    int n;
    int a;
    int waits;
    bit w;
    logic [DW-1:0] d;
    len = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    n   = (max_w > 0 && max_w < len) ? max_w : len;
    for (int i = 0; i < n; i++) begin
      a = addr_of(amode, i, len);
      case (dmode)
        0:       d = DW'(i & 1);
        1:       d = DW'(seed + 3 * i);
        default: d = DW'($urandom_range(0, 15));
      endcase
      bus.in_valid = 1'b1;
      bus.blk_len  = (AW+1)'(len_in);
      bus.wr_addr  = AW'(a);
      bus.in_data  = d;
      waits = 0;
      w     = 0;
      while (!w && waits < STALL_MAX) begin
        tick(w);
        waits++;
      end
      if (!w) begin
        check("write_stall", 32'(w), 1);
        break;
      end
      if (i == 0) t_w = edge_n;
      model[a] = d;
    end
    bus.in_valid = 1'b0;
    if (push)
      for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), model[k]});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  32'(bus.out_data),  0);
    check({tag, "_out_last"},  32'(bus.out_last),  0);
`ifdef PPBUF_ERR_EN
    check({tag, "_err_flags"}, 32'(err_flags), 0);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit w;
    bit seen_last;
    logic prev_rdy;
    int n;

    resetN        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.wr_addr   = '0;
    bus.blk_len   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // 192-word block, stride-13 permutation; word k came from i = 133k mod 192.
    for (int k = 0; k < 192; k++)
      exp_q.push_back({(k == 191), DW'(((k * 133) % 192) & 1)});
    seen_valid = 0;
    write_block(192, 0, 0, 0, 0, 0);
    drain(1000);
    check("latency_192", 32'(t_v + 1 - t_w), 193);

    // Two 96-word blocks with the sink stalled: both banks fill.
    bus.out_ready = 1'b0;
    write_block(96, 1, 1, 1, 1, 0);
    write_block(96, 2, 1, 9, 1, 0);
    check("in_ready_both_full", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    seen_last = 0;
    prev_rdy  = bus.in_ready;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick(w);
      n++;
      if (!seen_last && bus.out_valid && bus.out_last) begin
        seen_last = 1;
        check("in_ready_rise", 32'(bus.in_ready), 1);
        check("in_ready_before_free", 32'(prev_rdy), 0);
      end
      prev_rdy = bus.in_ready;
    end
    check("first_last_seen", 32'(seen_last), 1);
    drain(10);

    // Full-depth soft-bit block under random backpressure.
    rand_ready = 1;
    write_block(384, 2, 2, 0, 1, 0);
    drain(5000);
    rand_ready    = 0;
    bus.out_ready = 1'b1;

    // Single-word block, then a zero length clamped to DEPTH.
    seen_valid = 0;
    write_block(1, 3, 1, 5, 1, 0);
    drain(50);
    check("latency_len1", 32'(t_v - t_w), 1);
    write_block(0, 1, 1, 3, 1, 0);
    drain(1000);

    // Reset while a word is held on the output and a second block is half written.
    bus.out_ready = 1'b0;
    write_block(8, 3, 1, 1, 1, 0);
    write_block(192, 0, 1, 4, 0, 50);
    check("pre_reset_valid", 32'(bus.out_valid), 1);
    check("pre_reset_data", 32'(bus.out_data), 1);
    #2;
    resetN = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    write_block(192, 0, 1, 11, 1, 0);
    drain(1000);
    idle(8);

`ifdef PPBUF_ERR_EN
    bus.out_ready = 1'b0;
    write_block(4, 3, 1, 2, 1, 0);
    write_block(4, 1, 1, 6, 1, 0);
    check("err_clear", 32'(err_flags), 0);
    bus.in_valid = 1'b1;
    bus.blk_len  = (AW+1)'(4);
    bus.wr_addr  = '0;
    tick(w);
    bus.in_valid = 1'b0;
    check("err_overflow", 32'(err_flags), 32'(2'b01));
    bus.out_ready = 1'b1;
    drain(100);
    bus.in_valid = 1'b1;
    bus.blk_len  = (AW+1)'(192);
    bus.wr_addr  = AW'(200);
    bus.in_data  = '0;
    tick(w);
    bus.in_valid = 1'b0;
    check("err_addr_range", 32'(err_flags), 32'(2'b11));
    idle(4);
    check("err_sticky", 32'(err_flags), 32'(2'b11));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
